regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register bank's single write port between two write-back
//  requesters (req0: ALU/load path, req1: multi-cycle unit).
//  - Round-robin or fixed-priority arbitration with a valid/ready handshake.
//  - Registered output stage drives the bank's one-hot enable bus and data bus.
//  - Bypass port forwards the in-flight write to the decode stage.
//  Sits between the write-back muxes and the register bank, replacing the
//  direct enable-decoder path.
// PARAMETERS
//  DATA_LENGTH  32  width of write data
//  REGS_QTY     32  number of architectural registers; ADDR_LENGTH=$clog2(REGS_QTY)
//  FIXED_PRIO   0   0: round-robin; 1: req0 always wins
// PORTS
//  clk          in   1            clock; all state updates on rising edge
//  rst          in   1            reset, synchronous, active-high
//  stall        in   1            1: no grants this cycle
//  req0_valid   in   1            req0 write pending
//  req0_addr    in   ADDR_LENGTH  req0 destination register
//  req0_data    in   DATA_LENGTH  req0 write data
//  req0_ready   out  1            req0 accepted this cycle
//  req1_valid   in   1            req1 write pending
//  req1_addr    in   ADDR_LENGTH  req1 destination register
//  req1_data    in   DATA_LENGTH  req1 write data
//  req1_ready   out  1            req1 accepted this cycle
//  byp_addr     in   ADDR_LENGTH  register being read by decode
//  byp_hit      out  1            in-flight write targets byp_addr (never for x0)
//  byp_data     out  DATA_LENGTH  in-flight write data (valid when byp_hit)
//  wr_en        out  REGS_QTY     one-hot enable bus to the register bank
//  wr_d         out  DATA_LENGTH  data bus to the register bank
//  last_grant   out  1            requester granted most recently
// BEHAVIOUR
//  - Reset (rst=1 at an edge): wr_en=0, wr_d=0, byp_hit=0, last_grant=1,
//    so req0 wins the first tie.
//    readyN=0 while rst=1. A write in flight is discarded and never reaches the bank.
//  - Handshake: transfer when reqN_valid & reqN_ready in cycle N.
//    - readyN is combinational from valid, stall, rst and last_grant.
//    - At most one readyN=1 per cycle; readyN=0 whenever stall=1.
//    - A requester must hold valid/addr/data stable until ready.
//  - Arbitration, both valid:
//    - FIXED_PRIO=0: grant the requester != last_grant.
//    - FIXED_PRIO=1: grant req0.
//    - Single valid: that requester is granted.
//    - last_grant updates only on a transfer.
//  - Latency: transfer in cycle N -> wr_en one-hot and wr_d driven during
//    cycle N+1 for exactly one cycle; the bank captures at the end of N+1.
//    Back-to-back transfers give a new write every cycle (throughput 1).
//  - No transfer (idle or stall): wr_en=0 next cycle; wr_d holds its last value.
//  - x0: a transfer with addr 0 is accepted (ready=1, last_grant updates),
//    but wr_en stays 0 and byp_hit stays 0.
//  - Address >= REGS_QTY: accepted and dropped, wr_en=0.
//  - Bypass: byp_hit = |wr_en & (byp_addr == registered addr);
//    byp_data = wr_d. Both are combinational off the output stage.
//  - Same address from both requesters in consecutive transfers: the writes
//    reach the bank in grant order; the later one wins.
//  - Starvation: under FIXED_PRIO=0 neither requester waits more than 1 cycle
//    while stall=0.
// STRUCTURE
//  - Shared package regfile_pkg:
//    - DATA_LENGTH, REGS_QTY, ADDR_LENGTH constants
//    - SP_RST_VAL=32'h7fffeffc, GP_RST_VAL=32'h10008000
//    - wb_req_t {valid, addr, data}
//  - Sub-module rr_arbiter_2: 2-input round-robin/fixed arbiter holding last_grant.
//  - Top level holds the output stage registers: en_q, addr_q, data_q.
//  - Address-to-one-hot decode is inline.
// TESTING
//  1. rst=1 for 2 cycles, then release with no valid
//     -> wr_en=0, wr_d=0, last_grant=1, ready0=ready1=0 during rst.
//  2. req0 {addr=5, data=32'hDEADBEEF} alone
//     -> ready0=1 in cycle N; wr_en=32'h0000_0020 and wr_d=32'hDEADBEEF in
//        N+1 only; bank x5=32'hDEADBEEF.
//  3. Both valid for 4 cycles, addrs 6/7, FIXED_PRIO=0
//     -> grants 0,1,0,1; wr_en alternates bit6/bit7.
//     Same stimulus with FIXED_PRIO=1 -> req0 granted all 4 cycles, ready1=0.
//  4. req1 {addr=0, data=32'h1234}
//     -> ready1=1, wr_en=0 next cycle, byp_hit=0 with byp_addr=0,
//        last_grant=1, bank x0 stays 0.
//  5. Transfer addr=9 data=32'hA5A5A5A5, byp_addr=9 in N+1
//     -> byp_hit=1, byp_data=32'hA5A5A5A5; byp_addr=8 -> byp_hit=0.
//  6. stall=1 with both valid -> no ready, wr_en=0. Then a transfer in N with
//     rst=1 at the N+1 edge -> wr_en=0 after reset, and the bank is not
//     written by that transfer.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and the write-back request record
// used by the write-port arbiter.
package regfile_pkg;

  localparam int DATA_LENGTH = 32;
  localparam int REGS_QTY    = 32;
  localparam int ADDR_LENGTH = $clog2(REGS_QTY);

  localparam logic [31:0] SP_RST_VAL = 32'h7fffeffc;
  localparam logic [31:0] GP_RST_VAL = 32'h10008000;

  typedef struct packed {
    logic                   valid;
    logic [ADDR_LENGTH-1:0] addr;
    logic [DATA_LENGTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// One write-back request channel: the requester (master) drives
// valid/addr/data and the arbiter (slave) answers with ready.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int ADDR_W = regfile_pkg::ADDR_LENGTH,
  parameter int DATA_W = regfile_pkg::DATA_LENGTH
);

  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter_2.sv
// Two-input write-back arbiter: round-robin or fixed priority (req0 wins),
// holding the most recent grant so ties alternate.
module rr_arbiter_2
  import regfile_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1,
  output logic last_grant
);

  grant_e last_grant_q;
  grant_e last_grant_d;
  grant_e grant;

  // Ties go to the requester that did not win last; last_grant only moves on a transfer.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    grant  = last_grant_q;
    if (!rst && !stall) begin
      if (valid0 && valid1) begin
        grant = ((FIXED_PRIO != 0) || (last_grant_q == GRANT_REQ1)) ? GRANT_REQ0 : GRANT_REQ1;
      end else if (valid0) begin
        grant = GRANT_REQ0;
      end else if (valid1) begin
        grant = GRANT_REQ1;
      end
      ready0 = valid0 && (grant == GRANT_REQ0);
      ready1 = valid1 && (grant == GRANT_REQ1);
    end
    last_grant_d = (ready0 || ready1) ? grant : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_REQ1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = (last_grant_q == GRANT_REQ1);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register bank's single write port between two write-back
// requesters through a registered output stage with a decode bypass.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int DATA_LENGTH = regfile_pkg::DATA_LENGTH,
  parameter  int REGS_QTY    = regfile_pkg::REGS_QTY,
  parameter  int FIXED_PRIO  = 0,
  localparam int ADDR_LENGTH = $clog2(REGS_QTY)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  regfile_wb_arbiter_if.slave    req0,
  regfile_wb_arbiter_if.slave    req1,
  input  logic [ADDR_LENGTH-1:0] byp_addr,
  output logic                   byp_hit,
  output logic [DATA_LENGTH-1:0] byp_data,
  output logic [REGS_QTY-1:0]    wr_en,
  output logic [DATA_LENGTH-1:0] wr_d,
  output logic                   last_grant
);

  logic                   ready0;
  logic                   ready1;
  wb_req_t                sel;
  logic                   en_q;
  logic                   en_d;
  logic [ADDR_LENGTH-1:0] addr_q;
  logic [ADDR_LENGTH-1:0] addr_d;
  logic [DATA_LENGTH-1:0] data_q;
  logic [DATA_LENGTH-1:0] data_d;

  rr_arbiter_2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .valid0     (req0.valid),
    .valid1     (req1.valid),
    .ready0     (ready0),
    .ready1     (ready1),
    .last_grant (last_grant)
  );

  assign req0.ready = ready0;
  assign req1.ready = ready1;

  // x0 and out-of-range targets are accepted but never raise an enable.
  always_comb begin
    sel = '0;
    if (ready0) begin
      sel.valid = req0.valid;
      sel.addr  = req0.addr;
      sel.data  = req0.data;
    end else if (ready1) begin
      sel.valid = req1.valid;
      sel.addr  = req1.addr;
      sel.data  = req1.data;
    end
    en_d   = sel.valid && (sel.addr != '0) && (int'(sel.addr) < REGS_QTY);
    addr_d = sel.valid ? sel.addr : addr_q;
    data_d = sel.valid ? sel.data : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Masking with rst keeps a write caught by reset from landing in the bank.
  always_comb begin
    wr_en = '0;
    if (en_q && !rst) begin
      wr_en[addr_q] = 1'b1;
    end
  end

  assign wr_d     = data_q;
  assign byp_hit  = (|wr_en) && (byp_addr == addr_q);
  assign byp_data = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a round-robin instance plus a
// fixed-priority instance fed the same requests, and a model register bank.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic [4:0]  byp_addr;

  logic        byp_hit_a, byp_hit_b;
  logic [31:0] byp_data_a, byp_data_b;
  logic [31:0] wr_en_a, wr_en_b;
  logic [31:0] wr_d_a, wr_d_b;
  logic        last_grant_a, last_grant_b;

  logic [31:0] bank [32] = '{default: 32'h0};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if r0_a ();
  regfile_wb_arbiter_if r1_a ();
  regfile_wb_arbiter_if r0_b ();
  regfile_wb_arbiter_if r1_b ();

  assign r0_a.valid = v0;
  assign r0_a.addr  = a0;
  assign r0_a.data  = d0;
  assign r1_a.valid = v1;
  assign r1_a.addr  = a1;
  assign r1_a.data  = d1;
  assign r0_b.valid = v0;
  assign r0_b.addr  = a0;
  assign r0_b.data  = d0;
  assign r1_b.valid = v1;
  assign r1_b.addr  = a1;
  assign r1_b.data  = d1;

  regfile_wb_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req0       (r0_a),
    .req1       (r1_a),
    .byp_addr   (byp_addr),
    .byp_hit    (byp_hit_a),
    .byp_data   (byp_data_a),
    .wr_en      (wr_en_a),
    .wr_d       (wr_d_a),
    .last_grant (last_grant_a)
  );

  regfile_wb_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req0       (r0_b),
    .req1       (r1_b),
    .byp_addr   (byp_addr),
    .byp_hit    (byp_hit_b),
    .byp_data   (byp_data_b),
    .wr_en      (wr_en_b),
    .wr_d       (wr_d_b),
    .last_grant (last_grant_b)
  );

  // Model bank: captures whatever the round-robin instance enables at each edge.
  always @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (wr_en_a[i]) bank[i] <= wr_d_a;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; byp_addr = 5'd0;
    v0 = 1'b1; a0 = 5'd3; d0 = 32'h1;
    v1 = 1'b1; a1 = 5'd4; d1 = 32'h2;
    #1;
    n_checks++; if (r0_a.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready0: got %b expected 0", r0_a.ready); end
    n_checks++; if (r1_a.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready1: got %b expected 0", r1_a.ready); end
    step();
    step();
    n_checks++; if (wr_en_a !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wr_en: got %h expected 0", wr_en_a); end
    n_checks++; if (wr_d_a !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wr_d: got %h expected 0", wr_d_a); end
    n_checks++; if (last_grant_a !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_last_grant_rr: got %b expected 1", last_grant_a); end
    n_checks++; if (last_grant_b !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_last_grant_fp: got %b expected 1", last_grant_b); end
    n_checks++; if (byp_hit_a !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_byp_hit: got %b expected 0", byp_hit_a); end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    step();
    n_checks++; if (wr_en_a !== 32'h0) begin n_fail++; $display("[TB] FAIL idle_wr_en: got %h expected 0", wr_en_a); end
  endtask

  task automatic test_single();
    v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
    #1;
    n_checks++; if (r0_a.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_ready0: got %b expected 1", r0_a.ready); end
    n_checks++; if (r1_a.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ready1: got %b expected 0", r1_a.ready); end
    step();
    v0 = 1'b0;
    n_checks++; if (wr_en_a !== 32'h0000_0020) begin n_fail++; $display("[TB] FAIL single_wr_en: got %h expected 00000020", wr_en_a); end
    n_checks++; if (wr_d_a !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL single_wr_d: got %h expected deadbeef", wr_d_a); end
    n_checks++; if (last_grant_a !== 1'b0) begin n_fail++; $display("[TB] FAIL single_last_grant: got %b expected 0", last_grant_a); end
    step();
    n_checks++; if (wr_en_a !== 32'h0) begin n_fail++; $display("[TB] FAIL single_wr_en_after: got %h expected 0", wr_en_a); end
    n_checks++; if (wr_d_a !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL single_wr_d_hold: got %h expected deadbeef", wr_d_a); end
    n_checks++; if (bank[5] !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL single_bank_x5: got %h expected deadbeef", bank[5]); end
  endtask

  task automatic test_x0();
    v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
    #1;
    n_checks++; if (r1_a.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL x0_ready1_rr: got %b expected 1", r1_a.ready); end
    n_checks++; if (r1_b.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL x0_ready1_fp: got %b expected 1", r1_b.ready); end
    step();
    v1 = 1'b0; byp_addr = 5'd0;
    #1;
    n_checks++; if (wr_en_a !== 32'h0) begin n_fail++; $display("[TB] FAIL x0_wr_en: got %h expected 0", wr_en_a); end
    n_checks++; if (byp_hit_a !== 1'b0) begin n_fail++; $display("[TB] FAIL x0_byp_hit: got %b expected 0", byp_hit_a); end
    n_checks++; if (last_grant_a !== 1'b1) begin n_fail++; $display("[TB] FAIL x0_last_grant: got %b expected 1", last_grant_a); end
    step();
    n_checks++; if (bank[0] !== 32'h0) begin n_fail++; $display("[TB] FAIL x0_bank_x0: got %h expected 0", bank[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_en;
    v0 = 1'b1; a0 = 5'd6; d0 = 32'h0000_0600;
    v1 = 1'b1; a1 = 5'd7; d1 = 32'h0000_0700;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (r0_a.ready !== ((k % 2) == 0)) begin n_fail++; $display("[TB] FAIL rr_ready0[%0d]: got %b expected %b", k, r0_a.ready, (k % 2) == 0); end
      n_checks++; if (r1_a.ready !== ((k % 2) == 1)) begin n_fail++; $display("[TB] FAIL rr_ready1[%0d]: got %b expected %b", k, r1_a.ready, (k % 2) == 1); end
      n_checks++; if (r0_b.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fp_ready0[%0d]: got %b expected 1", k, r0_b.ready); end
      n_checks++; if (r1_b.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fp_ready1[%0d]: got %b expected 0", k, r1_b.ready); end
      step();
      exp_en = ((k % 2) == 0) ? 32'h0000_0040 : 32'h0000_0080;
      n_checks++; if (wr_en_a !== exp_en) begin n_fail++; $display("[TB] FAIL rr_wr_en[%0d]: got %h expected %h", k, wr_en_a, exp_en); end
      n_checks++; if (wr_en_b !== 32'h0000_0040) begin n_fail++; $display("[TB] FAIL fp_wr_en[%0d]: got %h expected 00000040", k, wr_en_b); end
    end
    v0 = 1'b0; v1 = 1'b0;
    step();
    n_checks++; if (bank[6] !== 32'h0000_0600) begin n_fail++; $display("[TB] FAIL rr_bank_x6: got %h expected 00000600", bank[6]); end
    n_checks++; if (bank[7] !== 32'h0000_0700) begin n_fail++; $display("[TB] FAIL rr_bank_x7: got %h expected 00000700", bank[7]); end
    n_checks++; if (last_grant_b !== 1'b0) begin n_fail++; $display("[TB] FAIL fp_last_grant: got %b expected 0", last_grant_b); end
  endtask

  task automatic test_bypass();
    v0 = 1'b1; a0 = 5'd9; d0 = 32'hA5A5A5A5;
    #1;
    n_checks++; if (r0_a.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL byp_ready0: got %b expected 1", r0_a.ready); end
    step();
    v0 = 1'b0; byp_addr = 5'd9;
    #1;
    n_checks++; if (byp_hit_a !== 1'b1) begin n_fail++; $display("[TB] FAIL byp_hit_9: got %b expected 1", byp_hit_a); end
    n_checks++; if (byp_data_a !== 32'hA5A5A5A5) begin n_fail++; $display("[TB] FAIL byp_data_9: got %h expected a5a5a5a5", byp_data_a); end
    byp_addr = 5'd8;
    #1;
    n_checks++; if (byp_hit_a !== 1'b0) begin n_fail++; $display("[TB] FAIL byp_hit_8: got %b expected 0", byp_hit_a); end
    step();
    byp_addr = 5'd9;
    #1;
    n_checks++; if (byp_hit_a !== 1'b0) begin n_fail++; $display("[TB] FAIL byp_hit_idle: got %b expected 0", byp_hit_a); end
  endtask

  task automatic test_stall_reset();
    stall = 1'b1;
    v0 = 1'b1; a0 = 5'd10; d0 = 32'h0000_0A0A;
    v1 = 1'b1; a1 = 5'd11; d1 = 32'h0000_0B0B;
    #1;
    n_checks++; if (r0_a.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_ready0_rr: got %b expected 0", r0_a.ready); end
    n_checks++; if (r1_a.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_ready1_rr: got %b expected 0", r1_a.ready); end
    n_checks++; if (r0_b.ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_ready0_fp: got %b expected 0", r0_b.ready); end
    step();
    n_checks++; if (wr_en_a !== 32'h0) begin n_fail++; $display("[TB] FAIL stall_wr_en: got %h expected 0", wr_en_a); end
    n_checks++; if (last_grant_a !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_last_grant: got %b expected 0", last_grant_a); end
    stall = 1'b0; v1 = 1'b0;
    a0 = 5'd12; d0 = 32'hCAFE0000;
    #1;
    n_checks++; if (r0_a.ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstflight_ready0: got %b expected 1", r0_a.ready); end
    step();
    v0 = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (wr_en_a !== 32'h0) begin n_fail++; $display("[TB] FAIL rstflight_wr_en_in_rst: got %h expected 0", wr_en_a); end
    step();
    n_checks++; if (wr_en_a !== 32'h0) begin n_fail++; $display("[TB] FAIL rstflight_wr_en: got %h expected 0", wr_en_a); end
    n_checks++; if (wr_d_a !== 32'h0) begin n_fail++; $display("[TB] FAIL rstflight_wr_d: got %h expected 0", wr_d_a); end
    n_checks++; if (last_grant_a !== 1'b1) begin n_fail++; $display("[TB] FAIL rstflight_last_grant: got %b expected 1", last_grant_a); end
    rst = 1'b0;
    step();
    n_checks++; if (bank[12] !== 32'h0) begin n_fail++; $display("[TB] FAIL rstflight_bank_x12: got %h expected 0", bank[12]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_x0();
    test_back_to_back();
    test_bypass();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
